col_id_dispatch: RTL and testbench
==================================

Name: col_id_dispatch

Overview:
- Producer end of the per-channel column-id FIFO interface consumed by bvb.
- Accepts one serial stream of column ids (CSR column indices of the sparse matrix) over a valid/ready handshake.
- Deals the ids round-robin across channel_num channels, buffering each channel in its own first-word-fall-through FIFO.
- Exposes id / id_fifo_empty / id_fifo_read exactly as bvb expects.

Parameters:
- channel_num, 4: number of parallel channels.
- col_id_size, 16: width of one column id in bits.
- fifo_depth, 8: entries per channel FIFO; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_id  input  col_id_size  incoming column id.
- in_valid  input  1  in_id is valid this cycle.
- in_last  input  1  marks in_id as the last id of a matrix row; qualified by in_valid.
- in_ready  output  1  dispatcher can accept in_id this cycle.
- id  output  channel_num*col_id_size  head entry of each channel FIFO; channel c occupies bits [c*col_id_size +: col_id_size].
- id_fifo_empty  output  channel_num  per-channel FIFO empty flag.
- id_fifo_read  input  channel_num  per-channel pop request from the consumer.
- id_fifo_full  output  channel_num  per-channel FIFO full flag, for debug and throttling.

Behaviour:
- Interface rule: clock port is clk; reset port is rst, synchronous and active-high.
- Reset values:
  - id_fifo_empty = all ones; id_fifo_full = 0.
  - id = 0 (all FIFO heads read as zero while empty).
  - Round-robin pointer = 0; all FIFO pointers and counts = 0.
  - in_ready is driven by the channel-0 full flag, so it reads 1 the first cycle after reset deasserts. While rst is high, no transfer is accepted.
- Round-robin pointer ptr, range 0..channel_num-1, selects the target channel.
- Transfer occurs when in_valid && in_ready.
  - in_ready = !id_fifo_full[ptr]. It is combinational on registered state only and never depends on in_valid.
  - On transfer, in_id is written to FIFO[ptr].
  - If in_last = 1, ptr returns to 0, so each row starts on channel 0. Otherwise ptr increments, wrapping from channel_num-1 to 0.
  - No transfer means ptr holds.
- FIFO behaviour, first-word-fall-through:
  - An id written at edge N is visible on id and clears id_fifo_empty after edge N (one-cycle latency). There is no same-cycle bypass from in_id to id.
  - id_fifo_read[c] pops channel c at the edge when id_fifo_empty[c] = 0. The next entry, or 0 if the FIFO is now empty, is presented after that edge.
  - id_fifo_read[c] while id_fifo_empty[c] = 1 is ignored: no pointer movement, no underflow.
- Full boundary:
  - id_fifo_full[c] = 1 when the count equals fifo_depth.
  - A write to a full channel is never accepted, even if that channel is popped in the same cycle (no pass-through). in_ready stays 0 for that cycle.
- Simultaneous write and pop on a non-empty, non-full channel: both take effect and the count is unchanged.
- Simultaneous write and pop on an empty channel: the pop is ignored and the write lands.
- Counts are log2(fifo_depth)+1 bits wide. Read and write pointers wrap modulo fifo_depth.
- Head-of-line blocking is intended: if the target channel is full, the whole input stream stalls even when other channels have space.
- Reset mid-operation: all buffered ids are discarded, ptr returns to 0, and the outputs take their reset values on the next edge. A transfer presented during the reset cycle is dropped.
- Channels are independent apart from the shared input pointer. Ordering within each channel is strictly FIFO.

Test Plan:
- Basic dispatch: reset, then stream ids 1..8 with in_last=0, no reads.
  - id_fifo_empty goes from 1111 to 0000.
  - Heads are ch0=1, ch1=2, ch2=3, ch3=4.
  - Popping all channels once gives heads 5,6,7,8.
- Row restart: send ids 10,11 (in_last on 11), then 12.
  - 12 lands in ch0 behind 10.
  - ch1 head is 11.
  - ch2 and ch3 stay empty.
- Full and backpressure: fifo_depth=8, no reads, 32 ids.
  - in_ready drops to 0 after the 32nd accept and id_fifo_full = 1111.
  - A 33rd valid id is held.
  - Popping ch0 once re-asserts in_ready the next cycle, and id 33 enters ch0.
- Pop on full with a pending write: ch0 full and ptr=0, in_valid=1, id_fifo_read[0]=1 in the same cycle.
  - The pop occurs and the write is refused (in_ready=0).
  - The write is accepted on the following cycle.
- Underflow: assert id_fifo_read=1111 for 5 cycles on empty FIFOs.
  - Flags stay 1111, id stays 0.
  - A later write of 0x00AA to ch0 appears as ch0 head one cycle after acceptance.
- Mid-stream reset: with 6 ids buffered and streaming active, pulse rst for 1 cycle.
  - The edge after rst: id_fifo_empty=1111, id=0, and the next accepted id lands in ch0.

Source files
------------

// File: rtl/col_id_dispatch.sv
// Column-id dispatcher: deals a serial id stream round-robin into per-channel
// first-word-fall-through FIFOs. Each row restarts on channel 0.
module col_id_dispatch #(
  parameter int channel_num = 4,
  parameter int col_id_size = 16,
  parameter int fifo_depth  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [col_id_size-1:0]             in_id,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [channel_num*col_id_size-1:0] id,
  output logic [channel_num-1:0]             id_fifo_empty,
  input  logic [channel_num-1:0]             id_fifo_read,
  output logic [channel_num-1:0]             id_fifo_full
);

  localparam int PW = (channel_num > 1) ? $clog2(channel_num) : 1;
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [channel_num-1:0][fifo_depth-1:0][col_id_size-1:0] mem_q, mem_d;
  logic [channel_num-1:0][AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [channel_num-1:0][CW-1:0] cnt_q, cnt_d;
  logic [channel_num-1:0] full_s, empty_s, push_s, pop_s;
  logic xfer_s;

  // Status flags and head-of-FIFO presentation; an empty head reads as zero.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    id      = '0;
    for (int c = 0; c < channel_num; c++) begin
      full_s[c]  = (cnt_q[c] == CW'(fifo_depth));
      empty_s[c] = (cnt_q[c] == CW'(0));
      if (empty_s[c]) begin
        id[c*col_id_size +: col_id_size] = '0;
      end else begin
        id[c*col_id_size +: col_id_size] = mem_q[c][rd_q[c]];
      end
    end
  end

  assign in_ready      = !full_s[ptr_q];
  assign id_fifo_empty = empty_s;
  assign id_fifo_full  = full_s;
  assign xfer_s        = in_valid && in_ready && !rst;

  // Next-state: round-robin pointer plus per-channel push/pop bookkeeping.
  always_comb begin
    ptr_d  = ptr_q;
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    push_s = '0;
    pop_s  = '0;

    if (xfer_s) begin
      if (in_last) begin
        ptr_d = PW'(0);
      end else if (ptr_q == PW'(channel_num - 1)) begin
        ptr_d = PW'(0);
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end

    for (int c = 0; c < channel_num; c++) begin
      // A full target never sees a push because in_ready already gates it.
      push_s[c] = xfer_s && (ptr_q == PW'(c));
      pop_s[c]  = id_fifo_read[c] && !empty_s[c];

      if (push_s[c]) begin
        mem_d[c][wr_q[c]] = in_id;
        wr_d[c]           = wr_q[c] + AW'(1);
      end else begin
        wr_d[c] = wr_q[c];
      end

      if (pop_s[c]) begin
        rd_d[c] = rd_q[c] + AW'(1);
      end else begin
        rd_d[c] = rd_q[c];
      end

      case ({push_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // State registers with synchronous reset discarding all buffered ids.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_col_id_dispatch.sv
// Directed bench for col_id_dispatch: dispatch order, row restart, full and
// backpressure, pop-on-full, underflow and mid-stream reset.
module tb_col_id_dispatch;

  localparam int CN = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_id;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [CN*W-1:0] id;
  logic [CN-1:0]   id_fifo_empty;
  logic [CN-1:0]   id_fifo_read;
  logic [CN-1:0]   id_fifo_full;

  int total = 0;
  int bad   = 0;

  col_id_dispatch #(.channel_num(CN), .col_id_size(W), .fifo_depth(8)) dut (
    .clk(clk), .rst(rst), .in_id(in_id), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .id(id), .id_fifo_empty(id_fifo_empty),
    .id_fifo_read(id_fifo_read), .id_fifo_full(id_fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; id_fifo_read = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] v, input logic last);
    int n;
    in_id = v; in_last = last; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("push_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop(input logic [CN-1:0] m);
    id_fifo_read = m;
    step();
    id_fifo_read = '0;
  endtask

  initial begin
    in_id = '0; in_valid = 1'b0; in_last = 1'b0; id_fifo_read = '0; rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_empty", 64'(id_fifo_empty), 64'hF);
    check("rst_full",  64'(id_fifo_full),  64'h0);
    check("rst_id",    id,                 64'h0);
    check("rst_ready", 64'(in_ready),      64'h1);

    // basic dispatch
    for (int i = 1; i <= 8; i++) push(16'(i), 1'b0);
    check("basic_empty", 64'(id_fifo_empty), 64'h0);
    check("basic_heads", id, 64'h0004_0003_0002_0001);
    pop(4'b1111);
    check("basic_pop1", id, 64'h0008_0007_0006_0005);
    pop(4'b1111);
    check("basic_drain", 64'(id_fifo_empty), 64'hF);
    check("basic_drain_id", id, 64'h0);

    // row restart
    push(16'd10, 1'b0);
    push(16'd11, 1'b1);
    push(16'd12, 1'b0);
    check("row_heads", id, 64'h0000_0000_000B_000A);
    check("row_empty", 64'(id_fifo_empty), 64'hC);
    pop(4'b0001);
    check("row_ch0_next", 64'(id[15:0]), 64'h000C);

    // full and backpressure
    do_reset();
    for (int i = 0; i < 32; i++) push(16'h0100 + 16'(i), 1'b0);
    check("full_ready", 64'(in_ready), 64'h0);
    check("full_flags", 64'(id_fifo_full), 64'hF);
    check("full_heads", id, 64'h0103_0102_0101_0100);
    in_id = 16'h0133; in_valid = 1'b1;
    step();
    step();
    check("held_ready", 64'(in_ready), 64'h0);
    check("held_ch0", 64'(id[15:0]), 64'h0100);
    // pop on full with pending write
    id_fifo_read = 4'b0001;
    check("pof_ready_before", 64'(in_ready), 64'h0);
    step();
    id_fifo_read = '0;
    check("pof_ch0_head", 64'(id[15:0]), 64'h0104);
    check("pof_refused", 64'(id_fifo_full), 64'hE);
    check("pof_ready_after", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("pof_accepted", 64'(id_fifo_full), 64'hF);
    check("pof_ready_ch1", 64'(in_ready), 64'h0);
    for (int i = 0; i < 7; i++) pop(4'b0001);
    check("pof_id33_in_ch0", 64'(id[15:0]), 64'h0133);

    // underflow, then write to an empty channel while it is being popped
    do_reset();
    id_fifo_read = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("uf_empty", 64'(id_fifo_empty), 64'hF);
      check("uf_id", id, 64'h0);
    end
    push(16'h00AA, 1'b0);
    id_fifo_read = '0;
    check("uf_write_head", id, 64'h0000_0000_0000_00AA);
    check("uf_write_empty", 64'(id_fifo_empty), 64'hE);

    // mid-stream reset
    do_reset();
    for (int i = 1; i <= 6; i++) push(16'h0200 + 16'(i), 1'b0);
    in_id = 16'h0077; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("mrst_empty", 64'(id_fifo_empty), 64'hF);
    check("mrst_id", id, 64'h0);
    check("mrst_full", 64'(id_fifo_full), 64'h0);
    push(16'h0055, 1'b0);
    check("mrst_next_ch0", id, 64'h0000_0000_0000_0055);
    check("mrst_next_empty", 64'(id_fifo_empty), 64'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
